round_poly_seq: RTL and testbench

//  Sequences the per-coefficient rounding unit over a whole polynomial in SNTRUP encapsulation.
//  For each coefficient it reads the source RAM, starts the rounding unit, waits for its done pulse and writes the result to the destination RAM.

---
 rtl/round_poly_seq.sv | 109 ++++++++++
 tb/tb_round_poly_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_poly_seq.sv
// Polynomial rounding sequencer: streams coefficients from the source RAM
// through the per-coefficient rounding unit into the destination RAM.
module round_poly_seq #(
  parameter int W   = 13,
  parameter int AW  = 10,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          rnd_start,
  output logic [W-1:0]  rnd_in,
  input  logic          rnd_done,
  input  logic [W-1:0]  rnd_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {
    IDLE, RD, WT, ST, RUN, WR, DN
  } state_t;

  state_t        state_q, state_n;
  logic [AW-1:0] src_q, dst_q, len_q, idx_q;
  logic [TW-1:0] tmo_q;
  logic [W-1:0]  res_q;
  logic          accept, tmo_hit;

  assign accept  = (state_q == IDLE) && start && !abort;
  assign tmo_hit = (tmo_q == TW'(TMO - 1));

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: if (start) state_n = (len == '0) ? DN : RD;
      RD:   state_n = WT;
      WT:   state_n = ST;
      ST:   state_n = RUN;
      RUN: begin
        if (rnd_done)     state_n = WR;
        else if (tmo_hit) state_n = DN;
      end
      WR:   state_n = (idx_q == len_q - AW'(1)) ? DN : RD;
      DN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      res_q     <= '0;
      rnd_in    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rnd_start <= 1'b0;
      wr_en     <= 1'b0;
    end else begin
      state_q   <= state_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DN);
      rd_en     <= (state_n == RD);
      rnd_start <= (state_n == ST);
      wr_en     <= (state_n == WR);
      if (accept) begin
        src_q <= src_base;
        dst_q <= dst_base;
        len_q <= len;
        idx_q <= '0;
        err   <= 1'b0;
      end
      if (state_q == WR && state_n == RD) idx_q <= idx_q + AW'(1);
      if (state_q == WT) rnd_in <= rd_data;
      if (state_q == ST) tmo_q <= '0;
      else if (state_q == RUN) tmo_q <= tmo_q + TW'(1);
      // Abort suppresses both the result capture and the timeout flag.
      if (state_q == RUN && !abort) begin
        if (rnd_done) res_q <= rnd_out;
        else if (tmo_hit) err <= 1'b1;
      end
    end
  end

  assign rd_addr = src_q + idx_q;
  assign wr_addr = dst_q + idx_q;
  assign wr_data = res_q;

endmodule

// File: tb/tb_round_poly_seq.sv
// Scoreboard bench for round_poly_seq with a RAM model and a
// round-to-multiple-of-3 rounder that answers k cycles after rnd_start.
module tb_round_poly_seq;
  localparam int W  = 13;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [AW-1:0] len = '0;
  logic          busy, done, err, rd_en, rnd_start, wr_en, rnd_done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  rd_data, rnd_in, rnd_out, wr_data;

  round_poly_seq #(.W(W), .AW(AW), .TMO(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .len(len),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rnd_start(rnd_start), .rnd_in(rnd_in),
    .rnd_done(rnd_done), .rnd_out(rnd_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] mem [1024];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int           k = 2;
  bit           mute = 1'b0;
  int           rcnt;
  logic [W-1:0] rval;

  function automatic logic [W-1:0] rnd3(input logic [W-1:0] v);
    case (v % 3)
      1: return v - 1'b1;
      2: return v + 1'b1;
      default: return v;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcnt <= 0;
    else if (rnd_start && !mute) begin
      rcnt <= k;
      rval <= rnd3(rnd_in);
    end else if (rcnt > 0) rcnt <= rcnt - 1;
  end
  assign rnd_done = (rcnt == 1);
  assign rnd_out  = rval;

  int passed = 0;
  int total  = 0;

  task automatic check(input string nm, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  logic [AW-1:0]   rdq [$];
  logic [AW+W-1:0] wrq [$];
  int n_rd = 0, n_wr = 0, n_rs = 0, n_done = 0, n_busy = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) n_busy++;
      if (rnd_start) n_rs++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (rd_en) begin
        n_rd++;
        if (rdq.size() == 0) check("rd_extra", 1, 0);
        else check("rd_addr", rd_addr, rdq.pop_front());
      end
      if (wr_en) begin
        n_wr++;
        if (wrq.size() == 0) check("wr_extra", 1, 0);
        else check("wr_addr_data", {wr_addr, wr_data}, wrq.pop_front());
      end
    end
  end

  task automatic go(input int s, input int d, input int l, output int c0);
    logic [31:0] sv, dv, lv;
    sv = s; dv = d; lv = l;
    @(posedge clk); #2;
    src_base = sv[AW-1:0];
    dst_base = dv[AW-1:0];
    len      = lv[AW-1:0];
    start    = 1'b1;
    c0       = cyc;
    @(posedge clk); #2;
    start    = 1'b0;
    src_base = 10'd777;
    dst_base = 10'd333;
    len      = 10'd9;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check({nm, "_idle_bound"}, longint'(n < budget), 1);
  endtask

  task automatic wait_rs(input int target, input int budget);
    int n = 0;
    while (n_rs < target && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check("rnd_start_bound", longint'(n < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int c0, b_rd, b_wr, b_rs, b_dn, b_bz;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 13'd5; mem[1] = 13'd761; mem[2] = 13'd1000;
    mem[3] = 13'd7; mem[1023] = 13'd10;

    repeat (3) @(posedge clk);
    #2;
    check("reset_ctrl", {busy, done, err, rd_en, wr_en, rnd_start}, 0);
    check("reset_data", {rd_addr, wr_addr, wr_data, rnd_in}, 0);
    rst_n = 1'b1;

    // len=3 normal run, k=2, plus a start while busy that must be ignored
    k = 2;
    rdq.push_back(10'd0); rdq.push_back(10'd1); rdq.push_back(10'd2);
    wrq.push_back({10'h100, 13'd6});
    wrq.push_back({10'h101, 13'd762});
    wrq.push_back({10'h102, 13'd999});
    b_dn = n_done; b_wr = n_wr;
    go(0, 'h100, 3, c0);
    @(posedge clk); #2;
    start = 1'b1; len = 10'd5; src_base = 10'd500; dst_base = 10'd7;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle("len3", 100);
    check("len3_done_cnt", n_done - b_dn, 1);
    check("len3_done_cycle", done_cyc - c0, 19);
    check("len3_wr_cnt", n_wr - b_wr, 3);
    check("len3_err", err, 0);

    // len=0
    b_rd = n_rd; b_wr = n_wr; b_rs = n_rs; b_dn = n_done; b_bz = n_busy;
    go(4, 4, 0, c0);
    wait_idle("len0", 10);
    repeat (2) @(posedge clk);
    #2;
    check("len0_done_cnt", n_done - b_dn, 1);
    check("len0_busy_cycles", n_busy - b_bz, 1);
    check("len0_no_access", (n_rd - b_rd) + (n_wr - b_wr) + (n_rs - b_rs), 0);

    // address wrap
    k = 1;
    rdq.push_back(10'd1023); rdq.push_back(10'd0);
    wrq.push_back({10'd1022, 13'd9});
    wrq.push_back({10'd1023, 13'd6});
    b_wr = n_wr;
    go(1023, 1022, 2, c0);
    wait_idle("wrap", 60);
    check("wrap_wr_cnt", n_wr - b_wr, 2);

    // timeout: rounder silent
    mute = 1'b1;
    rdq.push_back(10'd0);
    b_wr = n_wr; b_rs = n_rs; b_dn = n_done;
    go(0, 'h200, 2, c0);
    wait_idle("tmo", 200);
    check("tmo_err", err, 1);
    check("tmo_done_cnt", n_done - b_dn, 1);
    check("tmo_done_cycle", done_cyc - c0, 68);
    check("tmo_no_write", n_wr - b_wr, 0);
    check("tmo_rs_cnt", n_rs - b_rs, 1);
    mute = 1'b0; k = 2;
    rdq.push_back(10'd0);
    wrq.push_back({10'h300, 13'd6});
    go(0, 'h300, 1, c0);
    check("err_cleared", err, 0);
    wait_idle("after_tmo", 60);
    check("after_tmo_err", err, 0);

    // abort in RUN of coefficient 2 of 4
    k = 3;
    rdq.push_back(10'd0); rdq.push_back(10'd1);
    wrq.push_back({10'h010, 13'd6});
    b_rd = n_rd; b_wr = n_wr; b_rs = n_rs; b_dn = n_done;
    go(0, 'h10, 4, c0);
    wait_rs(b_rs + 2, 60);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    repeat (10) @(posedge clk);
    #2;
    check("abort_wr_cnt", n_wr - b_wr, 1);
    check("abort_rd_cnt", n_rd - b_rd, 2);
    check("abort_rs_cnt", n_rs - b_rs, 2);
    check("abort_no_done", n_done - b_dn, 0);
    check("abort_err", err, 0);

    // abort coinciding with rnd_done
    k = 1;
    rdq.push_back(10'd0);
    b_wr = n_wr; b_rs = n_rs; b_dn = n_done;
    go(0, 'h40, 1, c0);
    wait_rs(b_rs + 1, 20);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("abort_done_no_wr", n_wr - b_wr, 0);
    check("abort_done_no_done", n_done - b_dn, 0);
    check("abort_done_busy", busy, 0);

    // async reset mid-RUN, then a normal len=1 run
    mute = 1'b1;
    rdq.push_back(10'd0);
    b_rs = n_rs;
    go(0, 'h50, 1, c0);
    wait_rs(b_rs + 1, 20);
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", {busy, done, err, rd_en, wr_en, rnd_start}, 0);
    check("rst_data", {rd_addr, wr_addr, wr_data, rnd_in}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    mute = 1'b0; k = 2;
    rdq.push_back(10'd2);
    wrq.push_back({10'd5, 13'd999});
    b_dn = n_done;
    go(2, 5, 1, c0);
    wait_idle("post_rst", 60);
    check("post_rst_done", n_done - b_dn, 1);
    check("post_rst_err", err, 0);

    repeat (2) @(posedge clk);
    #2;
    check("rdq_empty", rdq.size(), 0);
    check("wrq_empty", wrq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
